// File: rtl/debug_packet_fifo.sv
// Store-and-forward flit FIFO between the trace packet converter and the debug NoC.
// Malformed or overflowing packets are discarded whole by rewinding the write pointer.
module debug_packet_fifo #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_last,
  input  logic        in_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  drop_count,
  output logic        err_pulse
);

  localparam logic [1:0]    IN_HDR  = 2'd0;
  localparam logic [1:0]    IN_BODY = 2'd1;
  localparam logic [1:0]    IN_DROP = 2'd2;
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0]   PTR_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] REM_ONE = AW'(1);
  localparam logic [15:0]   HDR_MAX = 16'(DEPTH - 1);

  logic [16:0]   mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d, cmt_q, cmt_d, rd_q, rd_d;
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [7:0]    drop_q, drop_d;
  logic          err_q;
  logic          wr_en, drop, full, hdr_ok, rd_en;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // Occupancy uses the registered read pointer: a same-cycle read never frees a slot
  assign full      = (wr_q - rd_q) == PTR_FULL;
  assign hdr_ok    = (in_data != 16'd0) && (in_data <= HDR_MAX) && !in_last;
  assign out_valid = (rd_q != cmt_q);
  assign rd_en     = out_valid && out_ready;
  assign {out_last, out_data} = mem_q[rd_q[AW-1:0]];
  assign drop_count = drop_q;
  assign err_pulse  = err_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wr_d    = wr_q;
    cmt_d   = cmt_q;
    wr_en   = 1'b0;
    drop    = 1'b0;
    if (in_valid) begin
      case (state_q)
        IN_HDR: begin
          if (!full && hdr_ok) begin
            wr_en   = 1'b1;
            wr_d    = wr_q + PTR_ONE;
            rem_d   = in_data[AW-1:0];
            state_d = IN_BODY;
          end else begin
            drop    = 1'b1;
            state_d = in_last ? IN_HDR : IN_DROP;
          end
        end
        IN_BODY: begin
          if (full) begin
            drop    = 1'b1;
            state_d = in_last ? IN_HDR : IN_DROP;
          end else if (rem_q == REM_ONE) begin
            if (in_last) begin
              wr_en   = 1'b1;
              wr_d    = wr_q + PTR_ONE;
              cmt_d   = wr_q + PTR_ONE;
              state_d = IN_HDR;
            end else begin
              drop    = 1'b1;
              state_d = IN_DROP;
            end
          end else if (in_last) begin
            drop    = 1'b1;
            state_d = IN_HDR;
          end else begin
            wr_en = 1'b1;
            wr_d  = wr_q + PTR_ONE;
            rem_d = rem_q - REM_ONE;
          end
        end
        IN_DROP: begin
          if (in_last) state_d = IN_HDR;
        end
        default: state_d = IN_HDR;
      endcase
    end
    // A discard throws away every uncommitted flit of the current packet
    if (drop) wr_d = cmt_q;
    drop_d = drop ? sat_inc(drop_q) : drop_q;
    rd_d   = rd_en ? rd_q + PTR_ONE : rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      cmt_q   <= '0;
      rd_q    <= '0;
      state_q <= IN_HDR;
      rem_q   <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      cmt_q   <= cmt_d;
      rd_q    <= rd_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      drop_q  <= drop_d;
      err_q   <= drop;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= {in_last, in_data};
  end

endmodule

// File: tb/tb_debug_packet_fifo.sv
// Directed and randomized checks of debug_packet_fifo against a queue-based packet model.
module tb_debug_packet_fifo;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  drop_count;
  logic        err_pulse;

  int checks = 0;
  int errors = 0;
  int handshakes = 0;

  // Model: committed flits visible downstream, flits of the packet being assembled
  logic [16:0] outq[$];
  logic [16:0] pend[$];
  int mode;   // 0 expect header, 1 in body, 2 skipping to last
  int rem;
  int mdrop;
  bit merr;

  debug_packet_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .drop_count(drop_count), .err_pulse(err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(outq.size() != 0));
    if (outq.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(outq[0][15:0]));
      chk("out_last", 32'(out_last), 32'(outq[0][16]));
    end
    chk("drop_count", 32'(drop_count), 32'(mdrop));
    chk("err_pulse", 32'(err_pulse), 32'(merr));
  endtask

  task automatic model_step(input logic v, input logic [15:0] d, input logic l, input logic r);
    bit full, drop;
    full = (outq.size() + pend.size()) == DEPTH;
    drop = 1'b0;
    if (r && outq.size() != 0) void'(outq.pop_front());
    if (v) begin
      case (mode)
        0: begin
          if (!full && d >= 1 && d <= DEPTH - 1 && !l) begin
            pend.push_back({1'b0, d});
            rem  = int'(d);
            mode = 1;
          end else begin
            drop = 1'b1;
            mode = l ? 0 : 2;
          end
        end
        1: begin
          if (full) begin
            drop = 1'b1;
            mode = l ? 0 : 2;
          end else if (rem == 1 && l) begin
            pend.push_back({1'b1, d});
            foreach (pend[i]) outq.push_back(pend[i]);
            pend.delete();
            mode = 0;
          end else if (rem == 1) begin
            drop = 1'b1;
            mode = 2;
          end else if (l) begin
            drop = 1'b1;
            mode = 0;
          end else begin
            pend.push_back({1'b0, d});
            rem--;
          end
        end
        default: if (l) mode = 0;
      endcase
    end
    if (drop) begin
      pend.delete();
      if (mdrop < 255) mdrop++;
    end
    merr = drop;
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    if (out_valid && out_ready) handshakes++;
    model_step(v, d, l, r);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    outq.delete();
    pend.delete();
    mode = 0; rem = 0; mdrop = 0; merr = 1'b0;
    handshakes = 0;
    check_outputs();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_pkt(input int n, input logic r);
    step(1'b1, 16'(n), 1'b0, r);
    for (int i = 0; i < n; i++) step(1'b1, 16'($urandom), (i == n - 1), r);
  endtask

  initial begin
    logic [15:0] exp35 [4];
    logic tog;
    exp35 = '{16'd3, 16'h1111, 16'h2222, 16'h3333};
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    mode = 0; rem = 0; mdrop = 0; merr = 1'b0;

    apply_reset();

    // Basic 3-flit packet, latency and ordering
    step(1'b1, 16'd3, 1'b0, 1'b1);
    step(1'b1, 16'h1111, 1'b0, 1'b1);
    step(1'b1, 16'h2222, 1'b0, 1'b1);
    chk("no_early_valid", 32'(out_valid), 32'd0);
    step(1'b1, 16'h3333, 1'b1, 1'b1);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_hdr", 32'(out_data), 32'(exp35[0]));
    chk("lat_hdr_last", 32'(out_last), 32'd0);
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 16'd0, 1'b0, 1'b1);
      chk("seq_data", 32'(out_data), 32'(exp35[i]));
      chk("seq_last", 32'(out_last), 32'(i == 3));
    end
    step(1'b0, 16'd0, 1'b0, 1'b1);
    chk("drained", 32'(out_valid), 32'd0);

    // Short packet is dropped, following packet intact
    apply_reset();
    step(1'b1, 16'd4, 1'b0, 1'b1);
    step(1'b1, 16'hAAAA, 1'b0, 1'b1);
    step(1'b1, 16'hBBBB, 1'b1, 1'b1);
    chk("short_err", 32'(err_pulse), 32'd1);
    chk("short_cnt", 32'(drop_count), 32'd1);
    step(1'b1, 16'd1, 1'b0, 1'b1);
    chk("short_err_once", 32'(err_pulse), 32'd0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 16'd0, 1'b0, 1'b1);
    chk("short_delivered", 32'(handshakes), 32'd2);

    // Zero-size header, then oversize header with its body
    apply_reset();
    step(1'b1, 16'd0, 1'b1, 1'b1);
    step(1'b1, 16'd40, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 16'(i + 100), (i == 4), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b0, 1'b1);
    chk("badhdr_cnt", 32'(drop_count), 32'd2);
    chk("badhdr_none_out", 32'(handshakes), 32'd0);

    // Overflow with downstream stalled
    apply_reset();
    for (int p = 0; p < 8; p++) send_pkt(4, 1'b0);
    chk("ovf_cnt", 32'(drop_count), 32'd2);
    chk("ovf_stored", 32'(outq.size()), 32'd30);
    for (int i = 0; i < 35; i++) step(1'b0, 16'd0, 1'b0, 1'b1);
    chk("ovf_delivered", 32'(handshakes), 32'd30);
    chk("ovf_empty", 32'(out_valid), 32'd0);

    // Wrap-around with toggling ready
    apply_reset();
    tog = 1'b0;
    for (int p = 0; p < 50; p++) begin
      step(1'b1, 16'd1, 1'b0, tog); tog = ~tog;
      step(1'b1, 16'($urandom), 1'b1, tog); tog = ~tog;
      step(1'b0, 16'd0, 1'b0, tog); tog = ~tog;
      step(1'b0, 16'd0, 1'b0, tog); tog = ~tog;
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 16'd0, 1'b0, tog); tog = ~tog;
    end
    chk("wrap_cnt", 32'(drop_count), 32'd0);
    chk("wrap_delivered", 32'(handshakes), 32'd100);

    // Reset while a packet is being assembled
    apply_reset();
    send_pkt(2, 1'b0);
    send_pkt(2, 1'b0);
    step(1'b1, 16'd3, 1'b0, 1'b0);
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    apply_reset();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    send_pkt(2, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 16'd0, 1'b0, 1'b1);
    chk("post_rst_delivered", 32'(handshakes), 32'd3);

    // Randomized traffic
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(1, 6));
      step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_packet_fifo.md
DEBUG_PACKET_FIFO -- requirements
Module: debug_packet_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 32, flit slots of storage (power of two, 8..256).
REQ-002 SHALL have parameter AW, default 5, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  16  flit payload from the trace-to-debug packet converter.
REQ-006 SHALL have port in_last  input  1  marks the final flit of a packet.
REQ-007 SHALL have port in_valid  input  1  flit present this cycle; no backpressure exists, so every valid flit is consumed.
REQ-008 SHALL have port out_data  output  16  flit payload toward the debug NoC.
REQ-009 SHALL have port out_last  output  1  last flag of out_data.
REQ-010 SHALL have port out_valid  output  1  a committed flit is available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the flit when high with out_valid.
REQ-012 SHALL have port drop_count  output  8  saturating count of discarded packets.
REQ-013 SHALL have port err_pulse  output  1  one-cycle registered pulse per discarded packet.

Function
REQ-014 SHALL store flits as {last, data} (17 bits) in a DEPTH-entry memory with AW+1-bit pointers wr_ptr, cmt_ptr and rd_ptr.
REQ-015 SHALL be store-and-forward: out_valid = (rd_ptr != cmt_ptr), so a packet is never visible downstream until its last flit is committed.
REQ-016 SHALL run an input FSM with states IN_HDR, IN_BODY and IN_DROP.
REQ-017 In IN_HDR, a valid flit is the size header; N = in_data is the count of flits that follow it.
REQ-018 A header SHALL be written and move the FSM to IN_BODY with remaining = N only if 1 <= N <= DEPTH-1, in_last = 0 and a free slot exists.
REQ-019 A header that fails REQ-018 SHALL be discarded; the FSM goes to IN_DROP, or stays in IN_HDR if in_last = 1.
REQ-020 In IN_BODY, each valid flit SHALL be written and SHALL decrement remaining.
REQ-021 When remaining = 1 and in_last = 1, the flit SHALL be written, cmt_ptr SHALL be set to wr_ptr+1 on the same edge, and the FSM SHALL return to IN_HDR.
REQ-022 In IN_BODY, in_last = 1 with remaining > 1 (short packet) SHALL discard the packet and return the FSM to IN_HDR.
REQ-023 In IN_BODY, remaining = 1 with in_last = 0 (long packet) SHALL discard the packet and move the FSM to IN_DROP.
REQ-024 A valid flit arriving when the memory is full (wr_ptr - rd_ptr = DEPTH) SHALL discard the packet; the FSM goes to IN_HDR if in_last = 1, otherwise to IN_DROP.
REQ-025 Discarding a packet SHALL rewind wr_ptr to cmt_ptr, increment drop_count (saturating at 255) and assert err_pulse on the next cycle.
REQ-026 IN_DROP SHALL ignore flits until a valid flit with in_last = 1, then go to IN_HDR; no further count or pulse is generated for these flits.
REQ-027 The full check SHALL use the registered rd_ptr, so a read in the same cycle does not free a slot for that cycle's write.
REQ-028 out_data and out_last SHALL be the memory entry at rd_ptr; rd_ptr SHALL increment when out_valid and out_ready are both high.
REQ-029 Read and write/commit in the same cycle SHALL both take effect; all pointers wrap modulo 2*DEPTH.
REQ-030 Latency: a last flit committed at edge t SHALL give out_valid = 1 after edge t if the FIFO was empty; the header appears first.
REQ-031 out_data SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-032 in_valid = 0 SHALL change no state except the read side.

Reset
REQ-033 On rst_n low, asynchronously: all pointers 0, FSM in IN_HDR, remaining 0, drop_count 0, err_pulse 0, out_valid 0.
REQ-034 Reset mid-packet SHALL lose all stored and partial packets; memory contents need not be cleared.

Verification
REQ-035 Header 3, then 0x1111, 0x2222, 0x3333 with last, out_ready = 1 -> out_valid rises the cycle after the last flit; outputs 3, 0x1111, 0x2222, 0x3333, with out_last only on 0x3333.
REQ-036 Header 4 then 2 flits with last on the 2nd (short packet) -> nothing output, drop_count = 1, one err_pulse; a following valid 1-flit packet is delivered intact.
REQ-037 Header 0, then header 40 (DEPTH = 32) with 5 flits and last -> drop_count = 2; out_valid never rises.
REQ-038 out_ready = 0, stream 8 packets of size 4 (5 flits each) -> 6 stored, 7th dropped at the 31st/32nd flit boundary, drop_count = 2; releasing out_ready yields exactly 6 intact packets.
REQ-039 Continuous 1-flit-body packets with out_ready toggling every cycle over pointer wrap-around -> ordered, lossless output with drop_count = 0.
REQ-040 Assert rst_n low during IN_BODY with 2 packets committed -> out_valid = 0 immediately; after release a new packet passes normally.
